game_tick_gen: RTL and testbench
================================

GAME_TICK_GEN -- requirements
Module: game_tick_gen

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent tick channels, range 1..8.
REQ-002 Parameter WIDTH, default 28: width of each rate register and down-counter.
REQ-003 Parameter DEFAULT_RATE, default 965664: reset reload value of every channel; SHALL fit in WIDTH bits.
REQ-004 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 enable  input  CHANNELS  per-channel run enable; low freezes that channel.
REQ-007 load  input  1  single-cycle strobe writing a new rate to one channel.
REQ-008 load_ch  input  3  target channel index for load.
REQ-009 load_rate  input  WIDTH  new reload value R for the target channel.
REQ-010 tick  output  CHANNELS  registered one-cycle pulse per channel period.
REQ-011 clk_out  output  CHANNELS  registered 50%-duty toggle output per channel (see Configuration).

Function
REQ-012 Each channel SHALL hold a rate register R[i] and a down-counter C[i], both WIDTH bits.
REQ-013 Enabled, no load: if C[i]==0, C[i] <= R[i]; else C[i] <= C[i]-1.
REQ-014 tick[i] SHALL be high for exactly the one cycle after an edge where enable[i]=1, C[i]==0 and no load targets channel i.
REQ-015 Tick period SHALL be R[i]+1 cycles; R[i]=0 gives tick[i] high every enabled cycle.
REQ-016 clk_out[i] SHALL invert on the same edge that sets tick[i]; output period is 2*(R[i]+1) cycles.
REQ-017 enable[i]=0: C[i] and clk_out[i] hold, tick[i]=0 next cycle; on re-enable, counting resumes from the held C[i].
REQ-018 load=1 with load_ch<CHANNELS: R[load_ch] <= load_rate and C[load_ch] <= load_rate on that edge, regardless of enable.
REQ-019 load with load_ch>=CHANNELS SHALL be ignored with no state change.
REQ-020 Load and C==0 on the same channel in the same cycle: load wins, no tick, clk_out holds.
REQ-021 A load SHALL NOT affect any non-targeted channel's R, C, tick or clk_out.
REQ-022 Counter arithmetic SHALL be WIDTH-bit unsigned; C never decrements below 0 (reload at 0, no wrap to all-ones).

Reset
REQ-023 resetn low SHALL asynchronously force R[i]=C[i]=DEFAULT_RATE, tick=0, clk_out=0 for all channels.
REQ-024 Reset asserted mid-period SHALL discard partial counts and loaded rates; after release the first tick occurs DEFAULT_RATE+1 enabled cycles later.
REQ-025 load and enable SHALL have no effect while resetn is low.

Configuration
REQ-026 Macro GAME_TICK_TOGGLE_EN defined: clk_out toggle flops per REQ-016 are built.
REQ-027 Macro GAME_TICK_TOGGLE_EN undefined: no toggle flops are built and clk_out is tied to all-zero; tick behaviour is unchanged.

Verification (WIDTH=8, DEFAULT_RATE=3, CHANNELS=4, GAME_TICK_TOGGLE_EN defined unless stated)
REQ-028 Release reset, enable=4'hF -> tick[0] pulses first 4 cycles after release, then every 4 cycles; clk_out[0] period 8 cycles.
REQ-029 Load ch1 rate 0 -> tick[1] high every cycle from the 2nd cycle after load; other channels keep their 4-cycle phase.
REQ-030 enable[2] low for 10 cycles mid-count at C=1 -> tick[2] stays 0; after re-enable, tick after exactly 2 cycles.
REQ-031 Load ch3 rate 5 in the cycle its C==0 -> no tick that period; next tick[3] 6 cycles later; load_ch=5 -> no change on any channel.
REQ-032 Assert resetn low mid-period with ch0 rate 9 -> outputs 0 immediately; after release ch0 period is 4 cycles.
REQ-033 Macro undefined -> clk_out stays 4'h0 throughout REQ-028 stimulus; tick timing identical.

Source files
------------

// File: rtl/game_tick_gen.sv
// game_tick_gen: multi-channel programmable tick generator.
// Each channel keeps a rate register and a down-counter. It emits a one-cycle
// tick every R+1 enabled cycles, plus an optional 50%-duty toggle output.
// Optional feature: define GAME_TICK_TOGGLE_EN to build the clk_out toggle
// flops. When it is undefined, clk_out is tied to zero.

// Per-channel counter lane
module game_tick_lane #(
    parameter int WIDTH        = 28,
    parameter int DEFAULT_RATE = 965664,
    parameter int IDX          = 0
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             enable,
    input  logic             load,
    input  logic [2:0]       load_ch,
    input  logic [WIDTH-1:0] load_rate,
    output logic             tick,
    output logic             clk_out
);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_RATE);

    logic [WIDTH-1:0] rate_q;
    logic [WIDTH-1:0] cnt_q;
    logic             load_hit;
    logic             expire;

    // A lane only answers to its own index, so an out-of-range load_ch never matches
    assign load_hit = load && (load_ch == 3'(IDX));
    // Terminal count is honoured only when running and not being overwritten
    assign expire   = enable && !load_hit && (cnt_q == '0);

    // Rate/count update: a load wins over everything; reload at zero, never wrap
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rate_q <= RST_VAL;
            cnt_q  <= RST_VAL;
            tick   <= 1'b0;
        end else if (load_hit) begin
            rate_q <= load_rate;
            cnt_q  <= load_rate;
            tick   <= 1'b0;
        end else if (enable) begin
            cnt_q  <= (cnt_q == '0) ? rate_q : cnt_q - WIDTH'(1);
            tick   <= (cnt_q == '0);
        end else begin
            tick   <= 1'b0;
        end
    end

`ifdef GAME_TICK_TOGGLE_EN
    // Toggle on the same edge that raises tick, giving a 2*(R+1) period square wave
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            clk_out <= 1'b0;
        else if (expire)
            clk_out <= ~clk_out;
    end
`else
    assign clk_out = 1'b0;
`endif
endmodule

// Top: array of independent lanes sharing the load bus
module game_tick_gen #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 28,
    parameter int DEFAULT_RATE = 965664
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [CHANNELS-1:0] enable,
    input  logic                load,
    input  logic [2:0]          load_ch,
    input  logic [WIDTH-1:0]    load_rate,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_out
);
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        game_tick_lane #(
            .WIDTH       (WIDTH),
            .DEFAULT_RATE(DEFAULT_RATE),
            .IDX         (g)
        ) u_lane (
            .CLOCK_50 (CLOCK_50),
            .resetn   (resetn),
            .enable   (enable[g]),
            .load     (load),
            .load_ch  (load_ch),
            .load_rate(load_rate),
            .tick     (tick[g]),
            .clk_out  (clk_out[g])
        );
    end
endmodule

// File: tb/tb_game_tick_gen.sv
// Directed self-checking bench for game_tick_gen (WIDTH=8, DEFAULT_RATE=3, CHANNELS=4).
// clk_out expectations follow GAME_TICK_TOGGLE_EN the same way the design does.
module tb_game_tick_gen;
    localparam int CH = 4;
    localparam int W  = 8;

    logic          CLOCK_50 = 1'b0;
    logic          resetn;
    logic [CH-1:0] enable;
    logic          load;
    logic [2:0]    load_ch;
    logic [W-1:0]  load_rate;
    logic [CH-1:0] tick;
    logic [CH-1:0] clk_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    game_tick_gen #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_RATE(3)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .enable   (enable),
        .load     (load),
        .load_ch  (load_ch),
        .load_rate(load_rate),
        .tick     (tick),
        .clk_out  (clk_out)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 4'hF; load = 1'b1; load_ch = 3'd0; load_rate = 8'd7;
        #1;
        repeat (3) step();
        total_cnt++;
        if (tick !== 4'h0) $display("FAIL reset_tick got=%h exp=0", tick);
        else pass_cnt++;
        total_cnt++;
        if (clk_out !== 4'h0) $display("FAIL reset_clk_out got=%h exp=0", clk_out);
        else pass_cnt++;
        resetn = 1'b1; load = 1'b0;
    endtask

    task automatic test_period();
        logic [11:0] seq [CH];
        logic [11:0] cseq;
        logic [11:0] cexp;
        for (int c = 0; c < CH; c++) seq[c] = '0;
        cseq = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            for (int c = 0; c < CH; c++) seq[c][k] = tick[c];
            cseq[k] = clk_out[0];
        end
        for (int c = 0; c < CH; c++) begin
            total_cnt++;
            if (seq[c] !== 12'h888) $display("FAIL period_tick ch%0d got=%h exp=888", c, seq[c]);
            else pass_cnt++;
        end
`ifdef GAME_TICK_TOGGLE_EN
        cexp = 12'h878;
`else
        cexp = 12'h000;
`endif
        total_cnt++;
        if (cseq !== cexp) $display("FAIL period_clk_out0 got=%h exp=%h", cseq, cexp);
        else pass_cnt++;
    endtask

    task automatic test_load_rate0();
        logic [7:0] s0, s1, s2;
        s0 = '0; s1 = '0; s2 = '0;
        load = 1'b1; load_ch = 3'd1; load_rate = 8'd0;
        for (int k = 0; k < 8; k++) begin
            step();
            load = 1'b0;
            s0[k] = tick[0]; s1[k] = tick[1]; s2[k] = tick[3];
        end
        total_cnt++;
        if (s1 !== 8'hFE) $display("FAIL rate0_ch1 got=%h exp=fe", s1);
        else pass_cnt++;
        total_cnt++;
        if (s0 !== 8'h88) $display("FAIL rate0_ch0_phase got=%h exp=88", s0);
        else pass_cnt++;
        total_cnt++;
        if (s2 !== 8'h88) $display("FAIL rate0_ch3_phase got=%h exp=88", s2);
        else pass_cnt++;
    endtask

    task automatic test_enable_freeze();
        logic seen;
        logic held;
        // ch2 just ticked (C=3); two edges leave it at C=1
        repeat (2) step();
        held = clk_out[2];
        enable = 4'b1011;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            seen = seen | tick[2];
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL freeze_tick2 got=%b exp=0", seen);
        else pass_cnt++;
        total_cnt++;
        if (clk_out[2] !== held) $display("FAIL freeze_clk_out2 got=%b exp=%b", clk_out[2], held);
        else pass_cnt++;
        enable = 4'hF;
        step();
        total_cnt++;
        if (tick[2] !== 1'b0) $display("FAIL resume_tick2_c1 got=%b exp=0", tick[2]);
        else pass_cnt++;
        step();
        total_cnt++;
        if (tick[2] !== 1'b1) $display("FAIL resume_tick2_c2 got=%b exp=1", tick[2]);
        else pass_cnt++;
    endtask

    task automatic test_load_collision();
        logic       found;
        logic       held;
        logic [5:0] s;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (tick[3]) found = 1'b1;
        end
        total_cnt++;
        if (!found) begin
            $display("FAIL collide_sync got=no_tick exp=tick3 within 20 cycles");
            return;
        end
        pass_cnt++;
        // C3=3 now; three edges bring it to 0, the fourth edge carries the load
        repeat (3) step();
        held = clk_out[3];
        load = 1'b1; load_ch = 3'd3; load_rate = 8'd5;
        step();
        load = 1'b0;
        total_cnt++;
        if (tick[3] !== 1'b0) $display("FAIL collide_tick3 got=%b exp=0", tick[3]);
        else pass_cnt++;
        total_cnt++;
        if (clk_out[3] !== held) $display("FAIL collide_clk_out3 got=%b exp=%b", clk_out[3], held);
        else pass_cnt++;
        s = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            s[k] = tick[3];
        end
        total_cnt++;
        if (s !== 6'b100000) $display("FAIL collide_next_tick3 got=%b exp=100000", s);
        else pass_cnt++;
        // Out-of-range load; rate 1 would shorten ch3 to a tick 3 edges in if accepted
        load = 1'b1; load_ch = 3'd5; load_rate = 8'd1;
        s = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            load = 1'b0;
            s[k] = tick[3];
        end
        total_cnt++;
        if (s !== 6'b100000) $display("FAIL bad_ch_ignored got=%b exp=100000", s);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] s0, s1;
        load = 1'b1; load_ch = 3'd0; load_rate = 8'd9;
        step();
        load = 1'b0;
        repeat (3) step();
        total_cnt++;
        if (tick[1] !== 1'b1) $display("FAIL pre_reset_tick1 got=%b exp=1", tick[1]);
        else pass_cnt++;
        resetn = 1'b0;
        #2;
        total_cnt++;
        if (tick !== 4'h0 || clk_out !== 4'h0)
            $display("FAIL async_reset got=%h/%h exp=0/0", tick, clk_out);
        else pass_cnt++;
        load = 1'b1; load_ch = 3'd0; load_rate = 8'd9;
        repeat (2) step();
        total_cnt++;
        if (tick !== 4'h0) $display("FAIL held_reset_tick got=%h exp=0", tick);
        else pass_cnt++;
        resetn = 1'b1; load = 1'b0;
        s0 = '0; s1 = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            s0[k] = tick[0]; s1[k] = tick[1];
        end
        total_cnt++;
        if (s0 !== 8'h88) $display("FAIL post_reset_ch0 got=%h exp=88", s0);
        else pass_cnt++;
        total_cnt++;
        if (s1 !== 8'h88) $display("FAIL post_reset_ch1 got=%h exp=88", s1);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_period();
        test_load_rate0();
        test_enable_freeze();
        test_load_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
